// File: rtl/tcp_app_notif_rx_pkg.sv
// Shared TCP NoC definitions used by the application new-flow notification receiver.
// Header flit layout, message type codes and the expected source fbits live here.
package tcp_app_notif_rx_pkg;

    localparam int NOC_DATA_WIDTH = 64;
    localparam int FLOWID_W       = 8;
    localparam int MSG_TYPE_W     = 8;
    localparam int MSG_LEN_W      = 8;
    localparam int FBITS_W        = 8;

    localparam logic [MSG_TYPE_W-1:0] TCP_NEW_FLOW_NOTIF     = 8'h03;
    localparam logic [FBITS_W-1:0]    TCP_RX_APP_NOTIF_FBITS = 8'h5A;

    typedef struct packed {
        logic [MSG_TYPE_W-1:0] msg_type;
        logic [MSG_LEN_W-1:0]  msg_len;
        logic [FBITS_W-1:0]    src_fbits;
        logic [FBITS_W-1:0]    dst_fbits;
    } tcp_noc_hdr_core;

    typedef struct packed {
        logic [FLOWID_W-1:0]    flowid;
        logic [31-FLOWID_W:0]   rsvd;
    } tcp_noc_hdr_inner;

    typedef struct packed {
        tcp_noc_hdr_core  core;
        tcp_noc_hdr_inner inner;
    } tcp_noc_hdr_flit;

    // A new-flow notification carries no body flits.
    function automatic logic is_new_flow_hdr(input logic [MSG_TYPE_W-1:0] msg_type,
                                             input logic [MSG_LEN_W-1:0]  msg_len);
        return (msg_type == TCP_NEW_FLOW_NOTIF) && (msg_len == '0);
    endfunction

endpackage

// File: rtl/tcp_app_notif_rx_if.sv
// NoC-side flit handshake and application-side new-flow handshake of the receiver.
interface tcp_app_notif_rx_if;
    import tcp_app_notif_rx_pkg::*;

    logic                      noc0_ctovr_app_notif_rx_val;
    logic [NOC_DATA_WIDTH-1:0] noc0_ctovr_app_notif_rx_data;
    logic                      app_notif_rx_noc0_ctovr_rdy;
    logic                      app_new_flow_val;
    logic [FLOWID_W-1:0]       app_new_flow_flowid;
    logic                      app_new_flow_rdy;

    modport slave (
        input  noc0_ctovr_app_notif_rx_val,
        input  noc0_ctovr_app_notif_rx_data,
        output app_notif_rx_noc0_ctovr_rdy,
        output app_new_flow_val,
        output app_new_flow_flowid,
        input  app_new_flow_rdy
    );

    modport master (
        output noc0_ctovr_app_notif_rx_val,
        output noc0_ctovr_app_notif_rx_data,
        input  app_notif_rx_noc0_ctovr_rdy,
        input  app_new_flow_val,
        input  app_new_flow_flowid,
        output app_new_flow_rdy
    );

endinterface

// File: rtl/tcp_app_notif_fifo.sv
// Pointer-based FIFO holding pending new-flow ids; pointers carry one extra wrap bit
// so full and empty are both decoded from registered pointers alone.
module tcp_app_notif_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/tcp_app_notif_rx.sv
// Receives TCP new-flow notification headers from the NoC and queues their flowids for the app.
// Define TCP_APP_NOTIF_SRC_CHECK_EN to also require the header source fbits to match.
module tcp_app_notif_rx
    import tcp_app_notif_rx_pkg::*;
#(
    parameter int NOTIF_FIFO_DEPTH = 4,
    parameter int DROP_CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tcp_app_notif_rx_if.slave     bus,
    output logic [DROP_CNT_W-1:0] notif_drop_cnt
);

    typedef enum logic {
        RX_HDR,
        RX_DRAIN
    } rx_state_e;

    localparam logic [MSG_LEN_W-1:0]  LEN_ONE = {{(MSG_LEN_W-1){1'b0}}, 1'b1};
    localparam logic [DROP_CNT_W-1:0] CNT_ONE = {{(DROP_CNT_W-1){1'b0}}, 1'b1};

    rx_state_e             state;
    rx_state_e             state_next;
    logic [MSG_LEN_W-1:0]  remaining;
    logic [MSG_LEN_W-1:0]  remaining_next;
    logic                  out_of_reset;
    tcp_noc_hdr_flit       hdr;
    logic                  hdr_accept;
    logic                  flit_xfer;
    logic                  push;
    logic                  drop;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  unused_hdr_bits;

    assign hdr = bus.noc0_ctovr_app_notif_rx_data;

`ifdef TCP_APP_NOTIF_SRC_CHECK_EN
    assign hdr_accept = is_new_flow_hdr(hdr.core.msg_type, hdr.core.msg_len)
                        && (hdr.core.src_fbits == TCP_RX_APP_NOTIF_FBITS);
`else
    assign hdr_accept = is_new_flow_hdr(hdr.core.msg_type, hdr.core.msg_len);
`endif

    assign unused_hdr_bits = ^{hdr.core.src_fbits, hdr.core.dst_fbits, hdr.inner.rsvd};

    // Ready looks only at registered pointers, so a pop in the same cycle cannot open the gate.
    assign bus.app_notif_rx_noc0_ctovr_rdy = out_of_reset && ((state == RX_DRAIN) || !fifo_full);
    assign flit_xfer = bus.noc0_ctovr_app_notif_rx_val && bus.app_notif_rx_noc0_ctovr_rdy;

    assign bus.app_new_flow_val = !fifo_empty;
    assign pop = bus.app_new_flow_val && bus.app_new_flow_rdy;

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        push           = 1'b0;
        drop           = 1'b0;
        case (state)
            RX_HDR: begin
                if (flit_xfer) begin
                    push = hdr_accept;
                    drop = !hdr_accept;
                    if (hdr.core.msg_len != '0) begin
                        state_next     = RX_DRAIN;
                        remaining_next = hdr.core.msg_len;
                    end
                end
            end
            RX_DRAIN: begin
                if (flit_xfer) begin
                    remaining_next = remaining - LEN_ONE;
                    if (remaining == LEN_ONE) state_next = RX_HDR;
                end
            end
            default: state_next = RX_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= RX_HDR;
            remaining      <= '0;
            out_of_reset   <= 1'b0;
            notif_drop_cnt <= '0;
        end else begin
            state        <= state_next;
            remaining    <= remaining_next;
            out_of_reset <= 1'b1;
            if (drop && (notif_drop_cnt != {DROP_CNT_W{1'b1}}))
                notif_drop_cnt <= notif_drop_cnt + CNT_ONE;
        end
    end

    tcp_app_notif_fifo #(
        .WIDTH (FLOWID_W),
        .DEPTH (NOTIF_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (hdr.inner.flowid),
        .pop       (pop),
        .pop_data  (bus.app_new_flow_flowid),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: doc/tcp_app_notif_rx.md
TCP_APP_NOTIF_RX -- requirements
Module: tcp_app_notif_rx

Interface
REQ-001 SHALL have parameter NOTIF_FIFO_DEPTH, default 4; pending new-flow entries; power of two, minimum 2.
REQ-002 SHALL have parameter DROP_CNT_W, default 16; width of the drop counter.
REQ-003 SHALL have port clk, input, 1 bit; the single clock.
REQ-004 SHALL have port rst_n, input, 1 bit; asynchronous, active-low reset.
REQ-005 SHALL have port noc0_ctovr_app_notif_rx_val, input, 1 bit; NoC flit valid.
REQ-006 SHALL have port noc0_ctovr_app_notif_rx_data, input, NOC_DATA_WIDTH bits; NoC flit, interpreted as tcp_noc_hdr_flit when it is a header.
REQ-007 SHALL have port app_notif_rx_noc0_ctovr_rdy, output, 1 bit; NoC flit ready.
REQ-008 SHALL have port app_new_flow_val, output, 1 bit; a new-flow entry is available.
REQ-009 SHALL have port app_new_flow_flowid, output, FLOWID_W bits; flowid of the head entry.
REQ-010 SHALL have port app_new_flow_rdy, input, 1 bit; the application consumes the head entry.
REQ-011 SHALL have port notif_drop_cnt, output, DROP_CNT_W bits; number of dropped headers.

Function
REQ-012 Flit transfer SHALL occur only when val && rdy; app transfer SHALL occur only when app_new_flow_val && app_new_flow_rdy.
REQ-013 FSM states SHALL be RX_HDR and RX_DRAIN; reset state is RX_HDR.
REQ-014 In RX_HDR, rdy SHALL equal !fifo_full; rdy SHALL be computed from registered occupancy only, so a same-cycle pop does not raise it.
REQ-015 A header is accepted iff core.msg_type == TCP_NEW_FLOW_NOTIF and core.msg_len == 0.
REQ-016 Accepted header: inner.flowid SHALL be pushed to the FIFO; app_new_flow_val SHALL assert the cycle after the transfer when the FIFO was empty.
REQ-017 Any other header SHALL NOT push; notif_drop_cnt SHALL increment by 1 and saturate at all-ones.
REQ-018 Header with msg_len != 0: load remaining = msg_len and go to RX_DRAIN.
REQ-019 RX_DRAIN: rdy = 1; each transfer decrements remaining; the transfer with remaining == 1 returns the FSM to RX_HDR.
REQ-020 FIFO SHALL be first-in first-out, with registered read/write pointers of log2(NOTIF_FIFO_DEPTH)+1 bits wrapping modulo 2*depth; full and empty SHALL be derived from the pointers.
REQ-021 Simultaneous push and pop SHALL leave occupancy unchanged; a pop when empty SHALL be ignored.
REQ-022 app_new_flow_flowid SHALL be stable while app_new_flow_val && !app_new_flow_rdy.
REQ-023 The block SHALL be valid-before-ready: app_new_flow_val SHALL NOT depend on app_new_flow_rdy.

Reset
REQ-024 While rst_n = 0: state RX_HDR, FIFO empty, remaining = 0, notif_drop_cnt = 0, app_new_flow_val = 0, rdy = 0.
REQ-025 Reset asserted mid-drain or with FIFO entries SHALL discard all pending state; rdy SHALL reassert on the first clock edge after rst_n deasserts.

Configuration
REQ-026 Macro TCP_APP_NOTIF_SRC_CHECK_EN: when defined, an accepted header SHALL additionally require core.src_fbits == TCP_RX_APP_NOTIF_FBITS; otherwise the header is dropped and counted per REQ-017.
REQ-027 When TCP_APP_NOTIF_SRC_CHECK_EN is undefined, src_fbits SHALL be ignored.

Structure
REQ-028 tcp_noc_hdr_flit, TCP_NEW_FLOW_NOTIF, TCP_RX_APP_NOTIF_FBITS and FLOWID_W SHALL come from the shared TCP package; the FSM state enum SHALL be local to the block.
REQ-029 The FIFO SHALL be a sub-module named tcp_app_notif_fifo (parameterised width/depth); the FSM and decode logic stay in the top module.

Verification
REQ-030 Test 1: one header, type TCP_NEW_FLOW_NOTIF, msg_len 0, flowid 5 -> app_new_flow_val = 1 next cycle, flowid = 5; pop -> val = 0.
REQ-031 Test 2: 4 headers, flowids 1-4, app_new_flow_rdy = 0 -> rdy = 0 after the 4th; 5th flit stalls; one pop -> rdy = 1 next cycle; output order 1,2,3,4,5.
REQ-032 Test 3: header of wrong msg_type with msg_len 3, then 3 body flits -> drop count = 1, no push, FSM back in RX_HDR; the next valid header (flowid 9) is delivered.
REQ-033 Test 4: simultaneous push (flowid 7) and pop with 2 entries -> occupancy stays 2, order preserved; 10 push/pop rounds exercise pointer wrap.
REQ-034 Test 5: rst_n pulsed low mid-drain with 3 entries queued -> val = 0 and drop count = 0; header flowid 2 afterwards is delivered.
REQ-035 Test 6 (macro defined): src_fbits mismatch -> dropped and counted; matching src_fbits -> delivered.
